// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, issues pipelined icache
//                reads and buffers returned {pc, inst} pairs for decode.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ic_ena,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] c_depth_cnt = (CW + 1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_inflight_pc;
    logic          r_inflight;
    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_push;
    logic          w_reissue;
    logic          w_issue;
    logic [CW:0]   w_credit;
    logic          w_unused;

    assign w_unused = ^redirect_pc[1:0];

    // The credit treats a head leaving this cycle as already free, so with
    // out_ready held high a new request can go out every cycle while the
    // occupancy (buffered + in flight) still never exceeds DEPTH.
    always_comb begin
        w_pop     = (r_count != '0) && out_ready && !redirect;
        w_push    = r_inflight && ic_valid && !redirect;
        w_reissue = !rst && !redirect && r_inflight && !ic_valid;
        w_credit  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
        w_issue   = !rst && !redirect && !w_reissue && (w_credit < c_depth_cnt);
    end

    assign ic_ena    = w_issue || w_reissue;
    assign ic_addr   = w_reissue ? r_inflight_pc : r_pc;
    assign out_valid = (r_count != '0);
    assign out_pc    = r_mem[r_rd_ptr][63:32];
    assign out_inst  = r_mem[r_rd_ptr][31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect) begin
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'd4;
        end else if (w_push) begin
            r_inflight <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_inflight_pc, ic_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with an icache responder
//                and a queue-based reference of the fetch stream.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ic_ena;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ic_ena      (ic_ena),
        .ic_addr     (ic_addr),
        .ic_valid    (ic_valid),
        .ic_data     (ic_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errs   = 0;
    int          checks = 0;

    // Reference state: buffered {pc, inst} entries, the one outstanding
    // request, and the next sequential address to be fetched.
    logic [63:0] q[$];
    logic        pend_v;
    logic [31:0] pend_addr;
    logic [31:0] exp_issue;
    logic [31:0] key;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend_v    = 1'b0;
        pend_addr = '0;
        exp_issue = RESET_PC;
    endtask

    // Drive one cycle's inputs (already just past the rising edge), then
    // check at the falling edge and advance the reference.
    task automatic body(input logic rdy, input logic redir, input logic [31:0] rpc, input logic drop);
        logic        acc;
        logic        reis;
        logic        e_ena;
        logic [31:0] e_addr;
        logic        room;
        out_ready   = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        ic_valid    = pend_v && !drop;
        ic_data     = pend_v ? (pend_addr ^ key) : $urandom;
        @(negedge clk);
        acc    = (q.size() != 0) && rdy && !redir;
        reis   = pend_v && drop && !redir;
        room   = (q.size() + int'(pend_v) - int'(acc)) < DEPTH;
        e_ena  = !redir && (reis || room);
        e_addr = reis ? pend_addr : exp_issue;
        chk("ic_ena", 32'(ic_ena), 32'(e_ena));
        chk("ic_addr", ic_addr, e_addr);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0][63:32]);
            chk("out_inst", out_inst, q[0][31:0]);
        end
        if (redir) begin
            q.delete();
            pend_v    = 1'b0;
            exp_issue = {rpc[31:2], 2'b00};
        end else begin
            if (acc) void'(q.pop_front());
            if (pend_v && !drop) q.push_back({pend_addr, pend_addr ^ key});
            if (e_ena && !reis) exp_issue = exp_issue + 32'd4;
            pend_v    = e_ena;
            pend_addr = e_addr;
        end
    endtask

    task automatic cyc(input logic rdy, input logic redir, input logic [31:0] rpc, input logic drop);
        @(posedge clk);
        #1;
        body(rdy, redir, rpc, drop);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        body(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int dcnt;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        ic_valid    = 1'b0;
        ic_data     = '0;
        out_ready   = 1'b0;
        key         = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ic_ena", 32'(ic_ena), 32'd0);
        chk("rst_ic_addr", ic_addr, RESET_PC);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);

        // Free run, word = address.
        release_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, '0, 1'b0);

        // Back-pressure from a fresh start, then drain.
        rst = 1'b1;
        #2;
        release_reset();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, '0, 1'b0);
        chk("fill_level", 32'(q.size()), 32'(DEPTH));
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, '0, 1'b0);

        // Three dropped responses for 0x00400008.
        rst = 1'b1;
        #2;
        release_reset();
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (pend_v && pend_addr == 32'h0040_0008 && dcnt < 3) begin
                dcnt++;
                cyc(1'b1, 1'b0, '0, 1'b1);
            end else begin
                cyc(1'b1, 1'b0, '0, 1'b0);
            end
        end
        chk("drop_count", 32'(dcnt), 32'd3);

        // Redirect with a full FIFO, unaligned target.
        key = 32'h5A5A_1234;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 32'h0040_0103, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0, 1'b0);

        // Address wrap at the top of memory.
        cyc(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, '0, 1'b0);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ic_ena", 32'(ic_ena), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_ic_addr", ic_addr, RESET_PC);
        release_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 0) key = $urandom;
            cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
